// File: rtl/mac1d_sched_if.sv
// Bundles the scheduler's config, request, MAC-operand and result signals.
// Latency: none, wiring only.
// Backpressure: none here; req_valid/req_ready and res_valid/res_ready are the handshakes.
// Ports (signals):
//   cfg_we/cfg_id/cfg_kernel          kernel table write
//   req_valid/req_ready/req_arr       per-requester windows and grants
//   mac_arr/mac_kernel/mac_in_vld     registered operands to the MAC
//   mac_result                        MAC output
//   res_valid/res_ready/res_data/res_id  tagged result stream
//   busy                              any work in flight or queued
// Modports: master = environment side, slave = scheduler side.
interface mac1d_sched_if #(
   parameter int NREQ        = 4,
   parameter int winW        = 3,
   parameter int winDataW    = 8,
   parameter int kernelDataW = 8,
   parameter int outputW     = 18
);
   localparam int IDW = $clog2(NREQ);

   logic                             cfg_we;
   logic [IDW-1:0]                   cfg_id;
   logic [winW*kernelDataW-1:0]      cfg_kernel;
   logic [NREQ-1:0]                  req_valid;
   logic [NREQ-1:0]                  req_ready;
   logic [NREQ*winW*winDataW-1:0]    req_arr;
   logic [winW*winDataW-1:0]         mac_arr;
   logic [winW*kernelDataW-1:0]      mac_kernel;
   logic                             mac_in_vld;
   logic [outputW-1:0]               mac_result;
   logic                             res_valid;
   logic                             res_ready;
   logic [outputW-1:0]               res_data;
   logic [IDW-1:0]                   res_id;
   logic                             busy;

   modport master (
      output cfg_we, cfg_id, cfg_kernel, req_valid, req_arr, mac_result, res_ready,
      input  req_ready, mac_arr, mac_kernel, mac_in_vld, res_valid, res_data, res_id, busy
   );

   modport slave (
      input  cfg_we, cfg_id, cfg_kernel, req_valid, req_arr, mac_result, res_ready,
      output req_ready, mac_arr, mac_kernel, mac_in_vld, res_valid, res_data, res_id, busy
   );
endinterface

// File: rtl/mac1d_sched.sv
// Round-robin scheduler sharing one MAC1D among NREQ window requesters, results tagged by id.
// Latency: MAC_LAT+1 cycles from request handshake to result at the FIFO head.
// Backpressure: grants stop when queued + in-flight results reach RES_DEPTH; res_ready drains the FIFO.
// Ports: clk, rst_n (async active-low); bus = mac1d_sched_if.slave carrying config, requests,
//        MAC operands/result and the result stream (see the interface header).
module mac1d_sched #(
   parameter int NREQ        = 4,
   parameter int winW        = 3,
   parameter int winDataW    = 8,
   parameter int kernelDataW = 8,
   parameter int outputW     = 18,
   parameter int MAC_LAT     = 0,
   parameter int RES_DEPTH   = 4
) (
   input logic           clk,
   input logic           rst_n,
   mac1d_sched_if.slave  bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int WW  = winW * winDataW;
   localparam int KW  = winW * kernelDataW;
   localparam int PW  = $clog2(RES_DEPTH);
   localparam int CW  = PW + 1;

   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } tag_t;

   typedef struct packed {
      logic [outputW-1:0] dat;
      logic [IDW-1:0]     id;
   } res_t;

   logic [KW-1:0]  kern_q [NREQ];
   logic [IDW-1:0] rr_q;
   logic [WW-1:0]  mac_arr_q;
   logic [KW-1:0]  mac_kernel_q;
   logic           mac_vld_q;
   tag_t           tag_q [MAC_LAT+1];
   res_t           mem_q [RES_DEPTH];
   logic [PW-1:0]  wr_ptr_q;
   logic [PW-1:0]  rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic [CW-1:0]  inflight_q;
   res_t           last_q;

   logic           credit_ok;
   logic           grant_ok;
   logic [IDW-1:0] grant_id;
   logic [IDW:0]   cand;
   logic           push;
   logic           pop;
   logic           res_vld;
   res_t           push_dat;
   res_t           head;

   assign res_vld  = (count_q != '0);
   assign push     = tag_q[MAC_LAT].vld;
   assign pop      = res_vld & bus.res_ready;
   assign push_dat = '{dat: bus.mac_result, id: tag_q[MAC_LAT].id};

   // Credit uses registered occupancy only, so a pop frees a slot one cycle later.
   assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(RES_DEPTH);

   // Round-robin search starting at rr_q. Gated by rst_n so no grant is shown while in reset.
   always_comb begin
      grant_ok = 1'b0;
      grant_id = '0;
      cand     = '0;
      if (rst_n && credit_ok) begin
         for (int o = 0; o < NREQ; o++) begin
            cand = {1'b0, rr_q} + (IDW+1)'(o);
            if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
            if (!grant_ok && bus.req_valid[cand[IDW-1:0]]) begin
               grant_ok = 1'b1;
               grant_id = cand[IDW-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) kern_q[i] <= '0;
         for (int s = 0; s <= MAC_LAT; s++) tag_q[s] <= '0;
         rr_q         <= '0;
         mac_arr_q    <= '0;
         mac_kernel_q <= '0;
         mac_vld_q    <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         inflight_q   <= '0;
         last_q       <= '0;
      end else begin
         // Issue reads kern_q before this write lands, so a same-cycle update affects only later issues.
         if (bus.cfg_we) kern_q[bus.cfg_id] <= bus.cfg_kernel;

         tag_q[0] <= '{vld: grant_ok, id: grant_id};
         for (int s = 1; s <= MAC_LAT; s++) tag_q[s] <= tag_q[s-1];

         mac_vld_q <= grant_ok;
         if (grant_ok) begin
            mac_arr_q    <= bus.req_arr[grant_id*WW +: WW];
            mac_kernel_q <= kern_q[grant_id];
            rr_q         <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
         end

         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            last_q   <= mem_q[rd_ptr_q];
         end

         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase

         case ({grant_ok, push})
            2'b10:   inflight_q <= inflight_q + CW'(1);
            2'b01:   inflight_q <= inflight_q - CW'(1);
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   // Storage needs no reset: nothing is read from it unless count_q says the entry is live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_dat;
   end

   // When empty the last popped entry is shown so res_data/res_id hold steady.
   assign head = res_vld ? mem_q[rd_ptr_q] : last_q;

   assign bus.req_ready  = grant_ok ? (NREQ'(1) << grant_id) : '0;
   assign bus.mac_arr    = mac_arr_q;
   assign bus.mac_kernel = mac_kernel_q;
   assign bus.mac_in_vld = mac_vld_q;
   assign bus.res_valid  = res_vld;
   assign bus.res_data   = head.dat;
   assign bus.res_id     = head.id;
   assign bus.busy       = (inflight_q != '0) | (count_q != '0);
endmodule

// File: tb/tb_mac1d_sched.sv
// Bench for mac1d_sched: two instances (MAC_LAT 0 and 2) share stimulus, each with its own
// transaction-level model (grant order, credit, result queue with arrival times) and monitor.
// Directed phases cover the listed scenarios, followed by a randomized phase.
module tb_mac1d_sched;
   localparam int NREQ  = 4;
   localparam int WIN   = 3;
   localparam int WD    = 8;
   localparam int KD    = 8;
   localparam int OW    = 18;
   localparam int DEPTH = 4;
   localparam int IDW   = $clog2(NREQ);
   localparam int WW    = WIN * WD;
   localparam int KW    = WIN * KD;

   typedef struct {
      logic [OW-1:0] d;
      int            id;
      int            rdy;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_we;
   logic [IDW-1:0]    cfg_id;
   logic [KW-1:0]     cfg_kernel;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*WW-1:0] req_arr;
   logic              res_ready;

   int cycle = 0;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cycle, act, exp);
      end
   endtask

   function automatic logic [OW-1:0] dot(input logic [WW-1:0] a, input logic [KW-1:0] k);
      int s;
      s = 0;
      for (int t = 0; t < WIN; t++) s += int'(a[t*WD +: WD]) * int'(k[t*KD +: KD]);
      return OW'(s);
   endfunction

   function automatic logic [KW-1:0] trip(input int v0, input int v1, input int v2);
      logic [KW-1:0] r;
      r[0 +: 8]  = 8'(v0);
      r[8 +: 8]  = 8'(v1);
      r[16 +: 8] = 8'(v2);
      return r;
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int id, input logic [KW-1:0] k);
      cfg_we = 1'b1; cfg_id = IDW'(id); cfg_kernel = k;
      tick();
      cfg_we = 1'b0;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int LAT = 2 * g;

      mac1d_sched_if #(.NREQ(NREQ), .winW(WIN), .winDataW(WD), .kernelDataW(KD), .outputW(OW)) bus ();

      assign bus.cfg_we     = cfg_we;
      assign bus.cfg_id     = cfg_id;
      assign bus.cfg_kernel = cfg_kernel;
      assign bus.req_valid  = req_valid;
      assign bus.req_arr    = req_arr;
      assign bus.res_ready  = res_ready;

      mac1d_sched #(.NREQ(NREQ), .winW(WIN), .winDataW(WD), .kernelDataW(KD), .outputW(OW),
                    .MAC_LAT(LAT), .RES_DEPTH(DEPTH)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      // External MAC: dot product with LAT register stages.
      if (LAT == 0) begin : g_comb
         assign bus.mac_result = dot(bus.mac_arr, bus.mac_kernel);
      end else begin : g_pipe
         logic [OW-1:0] sr [LAT];
         always @(posedge clk) begin
            sr[0] <= dot(bus.mac_arr, bus.mac_kernel);
            for (int s = 1; s < LAT; s++) sr[s] <= sr[s-1];
         end
         assign bus.mac_result = sr[LAT-1];
      end

      exp_t          q[$];
      int            rr = 0;
      int            issued = 0;
      int            popped = 0;
      int            dut_hs = 0;
      logic [KW-1:0] ktab [NREQ];
      logic          exp_mvld = 1'b0;
      logic [OW-1:0] last_d = '0;
      int            last_id = 0;

      // Issue side: predicts the grant for the coming edge and queues the expected result.
      always @(negedge clk) begin : issue
         int   gi;
         exp_t e;
         if (!rst_n) begin
            q.delete();
            rr = 0; issued = 0; popped = 0;
            for (int i = 0; i < NREQ; i++) ktab[i] = '0;
            exp_mvld = 1'b0; last_d = '0; last_id = 0;
            chk($sformatf("lat%0d reset outputs", LAT),
                64'({bus.req_ready, bus.res_valid, bus.busy, bus.mac_in_vld, bus.res_data, bus.res_id}), 64'(0));
         end else begin
            chk($sformatf("lat%0d mac_in_vld", LAT), 64'(bus.mac_in_vld), 64'(exp_mvld));
            chk($sformatf("lat%0d busy", LAT), 64'(bus.busy), 64'(issued != popped));
            gi = -1;
            if (DEPTH - (issued - popped) > 0) begin
               for (int o = 0; o < NREQ; o++) begin
                  int idx;
                  idx = (rr + o) % NREQ;
                  if (gi < 0 && req_valid[idx]) gi = idx;
               end
            end
            chk($sformatf("lat%0d req_ready", LAT), 64'(bus.req_ready), (gi >= 0) ? 64'(1) << gi : 64'(0));
            if (|(bus.req_ready & req_valid)) dut_hs++;
            if (gi >= 0) begin
               e.d   = dot(req_arr[gi*WW +: WW], ktab[gi]);
               e.id  = gi;
               e.rdy = cycle + 2 + LAT;
               q.push_back(e);
               issued++;
               rr = (gi + 1) % NREQ;
               exp_mvld = 1'b1;
            end else begin
               exp_mvld = 1'b0;
            end
            if (cfg_we) ktab[cfg_id] = cfg_kernel;
         end
      end

      // Monitor: compares the FIFO head against the oldest expected result once it is due.
      always @(negedge clk) begin : mon
         bit ev;
         #1;
         if (rst_n) begin
            ev = (q.size() > 0) && (q[0].rdy <= cycle);
            chk($sformatf("lat%0d res_valid", LAT), 64'(bus.res_valid), 64'(ev));
            if (ev) begin
               chk($sformatf("lat%0d res_data", LAT), 64'(bus.res_data), 64'(q[0].d));
               chk($sformatf("lat%0d res_id", LAT), 64'(bus.res_id), 64'(q[0].id));
               if (res_ready) begin
                  last_d  = q[0].d;
                  last_id = q[0].id;
                  void'(q.pop_front());
                  popped++;
               end
            end else begin
               chk($sformatf("lat%0d res_data hold", LAT), 64'(bus.res_data), 64'(last_d));
               chk($sformatf("lat%0d res_id hold", LAT), 64'(bus.res_id), 64'(last_id));
            end
         end
      end
   end

   initial begin
      int h0, h1;
      cfg_we = 1'b0; cfg_id = '0; cfg_kernel = '0;
      req_valid = '0; req_arr = '0; res_ready = 1'b1;
      tick(3);
      rst_n = 1'b1;

      // Idle after reset.
      tick(6);
      chk("idle lat0 outputs", 64'({g_lane[0].bus.req_ready, g_lane[0].bus.res_valid, g_lane[0].bus.busy,
          g_lane[0].bus.mac_in_vld}), 64'(0));

      // Single op: kernel {1,2,1} x window {10,20,30} = 80.
      cfg(0, trip(1, 2, 1));
      req_arr[0 +: WW] = trip(10, 20, 30);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      chk("single op lat0 valid", 64'(g_lane[0].bus.res_valid), 64'(1));
      chk("single op lat0 data", 64'(g_lane[0].bus.res_data), 64'(80));
      chk("single op lat0 id", 64'(g_lane[0].bus.res_id), 64'(0));
      tick(6);

      // All requesters held valid with the consumer always ready.
      cfg(1, trip(1, 1, 1)); cfg(2, trip(3, 0, 1)); cfg(3, trip(0, 2, 5));
      for (int i = 0; i < NREQ; i++) req_arr[i*WW +: WW] = trip(i + 1, 2 * i, 7);
      req_valid = 4'b1111;
      tick(16);
      req_valid = '0;
      tick(8);

      // Consumer stalled: credit allows exactly DEPTH grants.
      h0 = g_lane[0].dut_hs; h1 = g_lane[1].dut_hs;
      res_ready = 1'b0;
      req_valid = 4'b1111;
      tick(10);
      chk("stall lat0 grants", 64'(g_lane[0].dut_hs - h0), 64'(DEPTH));
      chk("stall lat2 grants", 64'(g_lane[1].dut_hs - h1), 64'(DEPTH));
      chk("stall lat0 req_ready", 64'(g_lane[0].bus.req_ready), 64'(0));
      res_ready = 1'b1;
      tick(14);
      req_valid = '0;
      tick(8);

      // Kernel rewrite in the cycle requester 1 issues: old kernel used, new one next time.
      cfg(1, trip(1, 1, 1));
      req_arr[1*WW +: WW] = trip(3, 4, 5);
      req_valid = 4'b0010;
      cfg_we = 1'b1; cfg_id = 2'd1; cfg_kernel = trip(0, 1, 0);
      tick();
      cfg_we = 1'b0; req_valid = '0;
      tick();
      chk("kernel old lat0 data", 64'(g_lane[0].bus.res_data), 64'(12));
      chk("kernel old lat0 id", 64'(g_lane[0].bus.res_id), 64'(1));
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      tick();
      chk("kernel new lat0 data", 64'(g_lane[0].bus.res_data), 64'(4));
      tick(6);

      // Reset with work in flight and queued (lat2 lane: 2 queued, 2 in flight).
      res_ready = 1'b0;
      req_valid = 4'b1111;
      tick(5);
      chk("pre-reset lat2 busy", 64'({g_lane[1].bus.busy, g_lane[1].bus.res_valid}), 64'(2'b11));
      rst_n = 1'b0;
      #1;
      chk("async reset lat2", 64'({g_lane[1].bus.req_ready, g_lane[1].bus.res_valid, g_lane[1].bus.busy,
          g_lane[1].bus.mac_in_vld, g_lane[1].bus.res_data, g_lane[1].bus.res_id}), 64'(0));
      chk("async reset lat0", 64'({g_lane[0].bus.req_ready, g_lane[0].bus.res_valid, g_lane[0].bus.busy,
          g_lane[0].bus.mac_in_vld, g_lane[0].bus.res_data, g_lane[0].bus.res_id}), 64'(0));
      tick(2);
      rst_n = 1'b1; req_valid = '0; res_ready = 1'b1;
      tick();
      cfg(2, trip(2, 0, 0));
      req_arr[2*WW +: WW] = trip(7, 1, 1);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      tick(3);
      chk("post-reset lat2 valid", 64'(g_lane[1].bus.res_valid), 64'(1));
      chk("post-reset lat2 id", 64'(g_lane[1].bus.res_id), 64'(2));
      chk("post-reset lat2 data", 64'(g_lane[1].bus.res_data), 64'(14));
      tick(4);

      // Randomized traffic.
      for (int n = 0; n < 800; n++) begin
         req_valid = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) req_arr[i*WW +: WW] = WW'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         cfg_we = ($urandom_range(0, 7) == 0);
         cfg_id = IDW'($urandom);
         cfg_kernel = KW'($urandom);
         tick();
      end
      cfg_we = 1'b0; req_valid = '0; res_ready = 1'b1;
      tick(20);
      chk("drain lat0 outstanding", 64'(g_lane[0].issued - g_lane[0].popped), 64'(0));
      chk("drain lat2 outstanding", 64'(g_lane[1].issued - g_lane[1].popped), 64'(0));
      chk("drain lat0 busy", 64'(g_lane[0].bus.busy), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
